// File: rtl/pkt_gen_pkg.sv
// rtl/pkt_gen_pkg.sv - shared packet header, error indices and size constants for the packet generator/checker pair
package pkt_gen_pkg;

  localparam int PKT_MIN_SIZE   = 8;
  localparam int BYTES_PER_BEAT = 8;

  typedef struct packed {
    logic [15:0] flow;
    logic [15:0] size;
    logic [31:0] seq;
  } pkt_hdr_t;

  typedef enum logic [1:0] {
    ERR_SIZE       = 2'd0,
    ERR_SEQ        = 2'd1,
    ERR_FLOW_RANGE = 2'd2,
    ERR_ORPHAN     = 2'd3
  } err_idx_e;

endpackage

// File: rtl/pkt_rx_flow_stats.sv
// rtl/pkt_rx_flow_stats.sv - per-flow packet/byte/error counters and expected sequence numbers
module pkt_rx_flow_stats #(
  parameter int FLOW_CNT       = 16,
  parameter int FLOW_CNT_WIDTH = (FLOW_CNT > 1) ? $clog2(FLOW_CNT) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      upd_val_i,
  input  logic [FLOW_CNT_WIDTH-1:0] upd_flow_i,
  input  logic [16:0]               upd_bytes_i,
  input  logic                      upd_err_i,
  input  logic [31:0]               upd_next_seq_i,
  output logic [31:0]               exp_seq_o,
  input  logic [FLOW_CNT_WIDTH-1:0] rd_addr_i,
  input  logic                      rd_req_i,
  input  logic                      rd_clr_i,
  output logic [31:0]               rd_pkt_cnt_o,
  output logic [31:0]               rd_byte_cnt_o,
  output logic [15:0]               rd_err_cnt_o,
  output logic                      rd_val_o
);

  logic [31:0] pkt_cnt_q  [FLOW_CNT];
  logic [31:0] byte_cnt_q [FLOW_CNT];
  logic [15:0] err_cnt_q  [FLOW_CNT];
  logic [31:0] exp_seq_q  [FLOW_CNT];
  logic [31:0] rd_pkt_q, rd_byte_q;
  logic [15:0] rd_err_q;
  logic        rd_val_q;

  assign exp_seq_o     = exp_seq_q[upd_flow_i];
  assign rd_pkt_cnt_o  = rd_pkt_q;
  assign rd_byte_cnt_o = rd_byte_q;
  assign rd_err_cnt_o  = rd_err_q;
  assign rd_val_o      = rd_val_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FLOW_CNT; i++) begin
        pkt_cnt_q[i]  <= '0;
        byte_cnt_q[i] <= '0;
        err_cnt_q[i]  <= '0;
        exp_seq_q[i]  <= '0;
      end
      rd_pkt_q  <= '0;
      rd_byte_q <= '0;
      rd_err_q  <= '0;
      rd_val_q  <= 1'b0;
    end else begin
      rd_val_q <= rd_req_i;
      // Read samples the registers before this cycle's update lands
      if (rd_req_i) begin
        rd_pkt_q  <= pkt_cnt_q[rd_addr_i];
        rd_byte_q <= byte_cnt_q[rd_addr_i];
        rd_err_q  <= err_cnt_q[rd_addr_i];
      end
      if (upd_val_i) begin
        exp_seq_q[upd_flow_i]  <= upd_next_seq_i;
        pkt_cnt_q[upd_flow_i]  <= pkt_cnt_q[upd_flow_i] + 32'd1;
        byte_cnt_q[upd_flow_i] <= byte_cnt_q[upd_flow_i] + {15'd0, upd_bytes_i};
        if (upd_err_i && (err_cnt_q[upd_flow_i] != 16'hFFFF))
          err_cnt_q[upd_flow_i] <= err_cnt_q[upd_flow_i] + 16'd1;
      end
      // Later assignment wins: clear beats a same-flow update, expected_seq survives
      if (rd_req_i && rd_clr_i) begin
        pkt_cnt_q[rd_addr_i]  <= '0;
        byte_cnt_q[rd_addr_i] <= '0;
        err_cnt_q[rd_addr_i]  <= '0;
      end
    end
  end

endmodule

// File: rtl/pkt_rx_checker.sv
// rtl/pkt_rx_checker.sv - packet stream sink: header parse, per-flow size/sequence checks, stats read port
module pkt_rx_checker
  import pkt_gen_pkg::*;
#(
  parameter int FLOW_CNT       = 16,
  parameter int FLOW_CNT_WIDTH = (FLOW_CNT > 1) ? $clog2(FLOW_CNT) : 1,
  parameter int DATA_W         = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [DATA_W-1:0]         pkt_data_i,
  input  logic                      pkt_sop_i,
  input  logic                      pkt_eop_i,
  input  logic [2:0]                pkt_empty_i,
  input  logic                      pkt_val_i,
  output logic                      pkt_ready_o,
  input  logic [FLOW_CNT_WIDTH-1:0] rd_addr_i,
  input  logic                      rd_req_i,
  input  logic                      rd_clr_i,
  output logic [31:0]               rd_pkt_cnt_o,
  output logic [31:0]               rd_byte_cnt_o,
  output logic [15:0]               rd_err_cnt_o,
  output logic                      rd_val_o,
  output logic [3:0]                err_sticky_o
);

  typedef enum logic {S_IDLE, S_IN_PKT} state_e;

  state_e      state_q;
  pkt_hdr_t    hdr_q, fin_hdr_q, in_hdr;
  logic [16:0] byte_acc_q, byte_acc_d, fin_bytes_q;
  logic        ready_q, fin_val_q, fin_trunc_q;
  logic [3:0]  sticky_q;
  logic [3:0]  beat_bytes;
  logic [17:0] acc_sum;
  logic        beat, fin_in_range, fin_size_err, fin_seq_err;
  logic [31:0] exp_seq;

  always_comb begin
    beat       = pkt_val_i && ready_q;
    in_hdr     = pkt_hdr_t'(pkt_data_i[DATA_W-1 -: 64]);
    beat_bytes = pkt_eop_i ? (4'(BYTES_PER_BEAT) - {1'b0, pkt_empty_i}) : 4'(BYTES_PER_BEAT);
    acc_sum    = {1'b0, byte_acc_q} + {14'd0, beat_bytes};
    byte_acc_d = acc_sum[17] ? 17'h1FFFF : acc_sum[16:0];
    fin_in_range = fin_hdr_q.flow < 16'(FLOW_CNT);
    fin_size_err = fin_trunc_q || (fin_bytes_q != {1'b0, fin_hdr_q.size})
                   || (fin_bytes_q < 17'(PKT_MIN_SIZE));
    fin_seq_err  = fin_hdr_q.seq != exp_seq;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      hdr_q       <= '0;
      byte_acc_q  <= '0;
      ready_q     <= 1'b0;
      fin_val_q   <= 1'b0;
      fin_hdr_q   <= '0;
      fin_bytes_q <= '0;
      fin_trunc_q <= 1'b0;
      sticky_q    <= '0;
    end else begin
      ready_q     <= 1'b1;
      fin_val_q   <= 1'b0;
      fin_trunc_q <= 1'b0;
      if (beat) begin
        if (pkt_sop_i) begin
          // A sop+eop arriving mid-packet loses its slot to the truncated packet's finalize
          if (state_q == S_IN_PKT) begin
            fin_val_q   <= 1'b1;
            fin_hdr_q   <= hdr_q;
            fin_bytes_q <= byte_acc_q;
            fin_trunc_q <= 1'b1;
          end else if (pkt_eop_i) begin
            fin_val_q   <= 1'b1;
            fin_hdr_q   <= in_hdr;
            fin_bytes_q <= {13'd0, beat_bytes};
          end
          hdr_q      <= in_hdr;
          byte_acc_q <= {13'd0, beat_bytes};
          state_q    <= pkt_eop_i ? S_IDLE : S_IN_PKT;
        end else if (state_q == S_IN_PKT) begin
          byte_acc_q <= byte_acc_d;
          if (pkt_eop_i) begin
            fin_val_q   <= 1'b1;
            fin_hdr_q   <= hdr_q;
            fin_bytes_q <= byte_acc_d;
            state_q     <= S_IDLE;
          end
        end else begin
          sticky_q[ERR_ORPHAN] <= 1'b1;
        end
      end
      if (fin_val_q) begin
        if (!fin_in_range) begin
          sticky_q[ERR_FLOW_RANGE] <= 1'b1;
        end else begin
          if (fin_size_err) sticky_q[ERR_SIZE] <= 1'b1;
          if (fin_seq_err)  sticky_q[ERR_SEQ]  <= 1'b1;
        end
      end
    end
  end

  assign pkt_ready_o  = ready_q;
  assign err_sticky_o = sticky_q;

  pkt_rx_flow_stats #(
    .FLOW_CNT       (FLOW_CNT),
    .FLOW_CNT_WIDTH (FLOW_CNT_WIDTH)
  ) u_stats (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .upd_val_i      (fin_val_q && fin_in_range),
    .upd_flow_i     (fin_hdr_q.flow[FLOW_CNT_WIDTH-1:0]),
    .upd_bytes_i    (fin_bytes_q),
    .upd_err_i      (fin_size_err || fin_seq_err),
    .upd_next_seq_i (fin_hdr_q.seq + 32'd1),
    .exp_seq_o      (exp_seq),
    .rd_addr_i      (rd_addr_i),
    .rd_req_i       (rd_req_i),
    .rd_clr_i       (rd_clr_i),
    .rd_pkt_cnt_o   (rd_pkt_cnt_o),
    .rd_byte_cnt_o  (rd_byte_cnt_o),
    .rd_err_cnt_o   (rd_err_cnt_o),
    .rd_val_o       (rd_val_o)
  );

endmodule

// File: tb/tb_pkt_rx_checker.sv
// tb/tb_pkt_rx_checker.sv - self-checking bench for pkt_rx_checker
module tb_pkt_rx_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] pkt_data = '0;
  logic        pkt_sop = 1'b0, pkt_eop = 1'b0, pkt_val = 1'b0;
  logic [2:0]  pkt_empty = '0;
  logic        pkt_ready;
  logic [3:0]  rd_addr = '0;
  logic        rd_req = 1'b0, rd_clr = 1'b0;
  logic [31:0] rd_pkt_cnt, rd_byte_cnt;
  logic [15:0] rd_err_cnt;
  logic        rd_val;
  logic [3:0]  err_sticky;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pkt;
    logic [31:0] bytes;
    logic [15:0] err;
  } rd_exp_t;
  rd_exp_t sb_q[$];

  always #5 clk = ~clk;

  pkt_rx_checker dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pkt_data_i    (pkt_data),
    .pkt_sop_i     (pkt_sop),
    .pkt_eop_i     (pkt_eop),
    .pkt_empty_i   (pkt_empty),
    .pkt_val_i     (pkt_val),
    .pkt_ready_o   (pkt_ready),
    .rd_addr_i     (rd_addr),
    .rd_req_i      (rd_req),
    .rd_clr_i      (rd_clr),
    .rd_pkt_cnt_o  (rd_pkt_cnt),
    .rd_byte_cnt_o (rd_byte_cnt),
    .rd_err_cnt_o  (rd_err_cnt),
    .rd_val_o      (rd_val),
    .err_sticky_o  (err_sticky)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic sop, input logic eop, input logic [2:0] empty);
    pkt_data  = d;
    pkt_sop   = sop;
    pkt_eop   = eop;
    pkt_empty = empty;
    pkt_val   = 1'b1;
    tick();
    pkt_val = 1'b0;
    pkt_sop = 1'b0;
    pkt_eop = 1'b0;
  endtask

  task automatic send_pkt(input int flow, input int hsize, input int seq, input int nbytes);
    int nbeats;
    nbeats = (nbytes + 7) / 8;
    for (int b = 0; b < nbeats; b++) begin
      logic [63:0] d;
      d = (b == 0) ? {16'(flow), 16'(hsize), 32'(seq)} : {$urandom, $urandom};
      send_beat(d, b == 0, b == nbeats - 1, (b == nbeats - 1) ? 3'(nbeats * 8 - nbytes) : 3'd0);
    end
  endtask

  task automatic do_read(input string name, input int addr, input logic clr,
                         input int e_pkt, input int e_bytes, input int e_err);
    rd_exp_t e, got;
    int wait_cyc;
    e.pkt = 32'(e_pkt);
    e.bytes = 32'(e_bytes);
    e.err = 16'(e_err);
    sb_q.push_back(e);
    rd_addr = 4'(addr);
    rd_clr  = clr;
    rd_req  = 1'b1;
    tick();
    rd_req = 1'b0;
    rd_clr = 1'b0;
    wait_cyc = 0;
    while (!rd_val && wait_cyc < 5) begin
      tick();
      wait_cyc++;
    end
    checks++;
    if (!rd_val || wait_cyc != 0) begin
      errors++;
      $display("FAIL %s rd_val latency: got %0d extra cycles (valid=%b), required 0", name, wait_cyc, rd_val);
      void'(sb_q.pop_front());
    end else begin
      got = sb_q.pop_front();
      if (rd_pkt_cnt !== got.pkt || rd_byte_cnt !== got.bytes || rd_err_cnt !== got.err) begin
        errors++;
        $display("FAIL %s read: got pkt=%0d bytes=%0d err=%0d, required pkt=%0d bytes=%0d err=%0d",
                 name, rd_pkt_cnt, rd_byte_cnt, rd_err_cnt, got.pkt, got.bytes, got.err);
      end
    end
  endtask

  task automatic check_sticky(input string name, input logic [3:0] exp);
    checks++;
    if (err_sticky !== exp) begin
      errors++;
      $display("FAIL %s sticky: got %b, required %b", name, err_sticky, exp);
    end
  endtask

  task automatic test_reset();
    tick(3);
    checks++;
    if (pkt_ready !== 1'b0 || rd_val !== 1'b0 || err_sticky !== 4'b0 ||
        rd_pkt_cnt !== 32'd0 || rd_byte_cnt !== 32'd0 || rd_err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b val=%b sticky=%b pkt=%0d bytes=%0d err=%0d, required all 0",
               pkt_ready, rd_val, err_sticky, rd_pkt_cnt, rd_byte_cnt, rd_err_cnt);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (pkt_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b, required 1", pkt_ready);
    end
  endtask

  task automatic test_good_flow();
    for (int s = 0; s < 3; s++) send_pkt(3, 64, s, 64);
    tick(2);
    do_read("flow3_good", 3, 1'b0, 3, 192, 0);
    check_sticky("flow3_good", 4'b0000);
  endtask

  task automatic test_size();
    send_pkt(5, 61, 0, 61);
    tick(2);
    do_read("flow5_empty", 5, 1'b0, 1, 61, 0);
    check_sticky("flow5_empty", 4'b0000);
    send_pkt(5, 60, 1, 61);
    tick(2);
    do_read("flow5_size_err", 5, 1'b0, 2, 122, 1);
    check_sticky("flow5_size_err", 4'b0001);
  endtask

  task automatic test_seq();
    send_pkt(2, 16, 0, 16);
    send_pkt(2, 16, 1, 16);
    send_pkt(2, 16, 3, 16);
    tick(2);
    do_read("flow2_seq_gap", 2, 1'b0, 3, 48, 1);
    check_sticky("flow2_seq_gap", 4'b0011);
    send_pkt(2, 16, 4, 16);
    tick(2);
    do_read("flow2_resync", 2, 1'b0, 4, 64, 1);
  endtask

  task automatic test_sop_mid_packet();
    send_beat({16'd1, 16'd32, 32'd0}, 1'b1, 1'b0, 3'd0);
    send_beat(64'h1111, 1'b0, 1'b0, 3'd0);
    send_beat({16'd1, 16'd24, 32'd1}, 1'b1, 1'b0, 3'd0);
    send_beat(64'h2222, 1'b0, 1'b0, 3'd5);
    send_beat(64'h3333, 1'b0, 1'b1, 3'd0);
    tick(2);
    do_read("flow1_truncated", 1, 1'b0, 2, 40, 1);
  endtask

  task automatic test_orphan();
    send_beat(64'hDEAD_BEEF, 1'b0, 1'b0, 3'd0);
    send_beat(64'hDEAD_BEEF, 1'b0, 1'b1, 3'd0);
    tick(2);
    check_sticky("orphan", 4'b1011);
    do_read("orphan_flow3", 3, 1'b0, 3, 192, 0);
    do_read("orphan_flow1", 1, 1'b0, 2, 40, 1);
  endtask

  task automatic test_flow_range();
    send_pkt(20, 8, 0, 8);
    tick(2);
    check_sticky("flow_range", 4'b1111);
    do_read("flow_range_alias", 4, 1'b0, 0, 0, 0);
  endtask

  task automatic test_read_clear_collision();
    send_pkt(7, 8, 0, 8);
    tick(2);
    send_pkt(7, 8, 1, 8);
    do_read("flow7_clr_old", 7, 1'b1, 1, 8, 0);
    do_read("flow7_after_clr", 7, 1'b0, 0, 0, 0);
    send_pkt(7, 8, 2, 8);
    tick(2);
    do_read("flow7_seq_kept", 7, 1'b0, 1, 8, 0);
  endtask

  task automatic test_reset_mid_packet();
    send_beat({16'd9, 16'd24, 32'd0}, 1'b1, 1'b0, 3'd0);
    send_beat(64'h4444, 1'b0, 1'b0, 3'd0);
    rst = 1'b1;
    #2;
    checks++;
    if (pkt_ready !== 1'b0 || err_sticky !== 4'b0) begin
      errors++;
      $display("FAIL mid_reset: got ready=%b sticky=%b, required 0 and 0000", pkt_ready, err_sticky);
    end
    tick(2);
    rst = 1'b0;
    tick();
    checks++;
    if (pkt_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_mid_reset: got %b, required 1", pkt_ready);
    end
    send_beat(64'h5555, 1'b0, 1'b1, 3'd0);
    tick(2);
    do_read("flow9_discarded", 9, 1'b0, 0, 0, 0);
    do_read("flow3_cleared", 3, 1'b0, 0, 0, 0);
    send_pkt(9, 8, 0, 8);
    tick(2);
    do_read("flow9_fresh", 9, 1'b0, 1, 8, 0);
    check_sticky("after_mid_reset", 4'b1000);
  endtask

  initial begin
    test_reset();
    test_good_flow();
    test_size();
    test_seq();
    test_sop_mid_packet();
    test_orphan();
    test_flow_range();
    test_read_clear_collision();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
